serial_subtractor: RTL

//  Bit-serial unsigned/two's-complement subtractor: computes A - B - bin one bit per clock, LSB first,

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first, through a single
// full-subtractor cell with a registered borrow. Start/busy/done handshake with a controller.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic [1:0]       fs;

   // Returns {borrow_out, difference} for one bit position.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      logic d;
      logic bo;
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
      return {bo, d};
   endfunction

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      fs      = full_sub(a_sh_q[0], b_sh_q[0], br_q);

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {fs[0], res_q[WIDTH-1:1]};
            br_d   = fs[1];
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // br_q here is the borrow into the MSB; fs[1] is the borrow out of it.
               state_d = DONE;
               done_d  = 1'b1;
               diff_d  = {fs[0], res_q[WIDTH-1:1]};
               bout_d  = fs[1];
               ovf_d   = br_q ^ fs[1];
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule
